ntt_bfly_pipe: RTL and testbench

- Parametrised, fully pipelined radix-2 NTT butterfly for the NTT datapath.
- Supports a per-sample mode select: forward Cooley-Tukey (CT) or inverse Gentleman-Sande (GS).
- Uses a generic modulus Q with Barrett reduction.
- Accepts one butterfly per cycle. Both modes have identical fixed latency, so a stage controller may interleave modes without bubbles.

---
 rtl/ntt_pkg.sv | 32 +++
 rtl/ntt_modmul.sv | 104 ++++++++++
 rtl/ntt_bfly_pipe.sv | 173 +++++++++++++++++
 tb/tb_ntt_bfly_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, mode encoding and latency helper for the NTT butterfly.
// Build macro NTT_HALF_SCALE_EN adds a GS half-scaling stage and one cycle of latency.
package ntt_pkg;

    localparam int NTT_WIDTH   = 16;
    localparam int NTT_MODULUS = 12289;

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } ntt_mode_e;

    function automatic int barrett_shift(input int width);
        return 2 * width;
    endfunction

    // Holds for width <= 31 so that 2^(2*width) fits the 64-bit numerator.
    function automatic logic [63:0] barrett_k(input int width, input int modulus);
        logic [63:0] num;
        num = 64'd1 << barrett_shift(width);
        return num / 64'(modulus);
    endfunction

    function automatic int ntt_lat(input int mul_stages);
`ifdef NTT_HALF_SCALE_EN
        return mul_stages + 3;
`else
        return mul_stages + 2;
`endif
    endfunction

endpackage

// File: rtl/ntt_modmul.sv
// Pipelined Barrett a*b mod Q with STAGES register stages; the product is formed
// on entry, the reduction happens in the last stage, and (x, mode) ride alongside.
module ntt_modmul
    import ntt_pkg::*;
#(
    parameter int WIDTH   = NTT_WIDTH,
    parameter int MODULUS = NTT_MODULUS,
    parameter int STAGES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] in_x,
    input  logic             in_mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_x,
    output logic             out_mode
);

    localparam int            PW = barrett_shift(WIDTH);
    localparam logic [PW-1:0] K  = PW'(barrett_k(WIDTH, MODULUS));
    localparam logic [PW-1:0] QP = PW'(MODULUS);

    // The quotient estimate is at most one low, so a single subtract finishes.
    function automatic logic [WIDTH-1:0] barrett_reduce(input logic [PW-1:0] p);
        logic [PW-1:0] qt;
        logic [PW-1:0] r;
        qt = PW'(({{PW{1'b0}}, p} * {{PW{1'b0}}, K}) >> PW);
        r  = p - qt * QP;
        if (r >= QP) r = r - QP;
        return WIDTH'(r);
    endfunction

    logic [STAGES-1:0] vld_d, vld_q;
    logic [STAGES-1:0] mode_d, mode_q;
    logic [WIDTH-1:0]  x_d [STAGES];
    logic [WIDTH-1:0]  x_q [STAGES];
    logic [PW-1:0]     prod_in;
    logic [PW-1:0]     last_in;
    logic [WIDTH-1:0]  res_d, res_q;

    assign prod_in = PW'(a) * PW'(b);

    always_comb begin
        vld_d[0]  = in_valid;
        x_d[0]    = in_valid ? in_x : x_q[0];
        mode_d[0] = in_valid ? in_mode : mode_q[0];
        for (int i = 1; i < STAGES; i++) begin
            vld_d[i]  = vld_q[i-1];
            x_d[i]    = vld_q[i-1] ? x_q[i-1] : x_q[i];
            mode_d[i] = vld_q[i-1] ? mode_q[i-1] : mode_q[i];
        end
        res_d = vld_d[STAGES-1] ? barrett_reduce(last_in) : res_q;
    end

    generate
        if (STAGES == 1) begin : g_direct
            assign last_in = prod_in;
        end else begin : g_chain
            logic [PW-1:0] prod_d [STAGES-1];
            logic [PW-1:0] prod_q [STAGES-1];

            always_comb begin
                prod_d[0] = vld_d[0] ? prod_in : prod_q[0];
                for (int j = 1; j < STAGES - 1; j++) begin
                    prod_d[j] = vld_d[j] ? prod_q[j-1] : prod_q[j];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < STAGES - 1; j++) prod_q[j] <= '0;
                end else begin
                    for (int j = 0; j < STAGES - 1; j++) prod_q[j] <= prod_d[j];
                end
            end

            assign last_in = prod_q[STAGES-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            mode_q <= '0;
            res_q  <= '0;
            for (int i = 0; i < STAGES; i++) x_q[i] <= '0;
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            res_q  <= res_d;
            for (int i = 0; i < STAGES; i++) x_q[i] <= x_d[i];
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_r     = res_q;
    assign out_x     = x_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];

endmodule

// File: rtl/ntt_bfly_pipe.sv
// Fully pipelined radix-2 NTT butterfly, CT forward or GS inverse per sample.
// Define NTT_HALF_SCALE_EN to halve GS results mod Q in one extra output stage.
module ntt_bfly_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH      = NTT_WIDTH,
    parameter int MODULUS    = NTT_MODULUS,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] xin,
    input  logic [WIDTH-1:0] yin,
    input  logic [WIDTH-1:0] wr,
    input  logic             mode,
    input  logic             en,
    output logic [WIDTH-1:0] xout,
    output logic [WIDTH-1:0] yout,
    output logic             valid
);

    localparam logic [WIDTH:0] QW = (WIDTH+1)'(MODULUS);

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] u, input logic [WIDTH-1:0] v);
        logic [WIDTH:0] s;
        s = {1'b0, u} + {1'b0, v};
        if (s >= QW) s = s - QW;
        return WIDTH'(s);
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] u, input logic [WIDTH-1:0] v);
        logic [WIDTH:0] s;
        s = {1'b0, u} - {1'b0, v};
        if (u < v) s = s + QW;
        return WIDTH'(s);
    endfunction

    logic             s0_vld_d, s0_vld_q;
    logic [WIDTH-1:0] s0_x_d, s0_x_q, s0_y_d, s0_y_q, s0_w_d, s0_w_q;
    ntt_mode_e        s0_mode_d, s0_mode_q;

    always_comb begin
        s0_vld_d  = en;
        s0_x_d    = en ? xin : s0_x_q;
        s0_y_d    = en ? yin : s0_y_q;
        s0_w_d    = en ? wr : s0_w_q;
        s0_mode_d = en ? ntt_mode_e'(mode) : s0_mode_q;
    end

    // GS does its add/sub ahead of the multiplier, in the multiplier's entry stage.
    logic [WIDTH-1:0] mul_a, mul_x;

    always_comb begin
        if (s0_mode_q == MODE_GS) begin
            mul_a = mod_sub(s0_x_q, s0_y_q);
            mul_x = mod_add(s0_x_q, s0_y_q);
        end else begin
            mul_a = s0_y_q;
            mul_x = s0_x_q;
        end
    end

    logic             mm_vld, mm_mode;
    logic [WIDTH-1:0] mm_r, mm_x;

    ntt_modmul #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .STAGES  (MUL_STAGES)
    ) u_modmul (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s0_vld_q),
        .a         (mul_a),
        .b         (s0_w_q),
        .in_x      (mul_x),
        .in_mode   (s0_mode_q),
        .out_valid (mm_vld),
        .out_r     (mm_r),
        .out_x     (mm_x),
        .out_mode  (mm_mode)
    );

    logic             bf_vld_d, bf_vld_q;
    logic [WIDTH-1:0] bf_x, bf_y;
    logic [WIDTH-1:0] bf_x_d, bf_x_q, bf_y_d, bf_y_q;
    logic             bf_mode_d, bf_mode_q;

    always_comb begin
        if (mm_mode == MODE_GS) begin
            bf_x = mm_x;
            bf_y = mm_r;
        end else begin
            bf_x = mod_add(mm_x, mm_r);
            bf_y = mod_sub(mm_x, mm_r);
        end
        bf_vld_d  = mm_vld;
        bf_x_d    = mm_vld ? bf_x : bf_x_q;
        bf_y_d    = mm_vld ? bf_y : bf_y_q;
        bf_mode_d = mm_vld ? mm_mode : bf_mode_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_vld_q  <= 1'b0;
            s0_x_q    <= '0;
            s0_y_q    <= '0;
            s0_w_q    <= '0;
            s0_mode_q <= MODE_CT;
            bf_vld_q  <= 1'b0;
            bf_x_q    <= '0;
            bf_y_q    <= '0;
            bf_mode_q <= 1'b0;
        end else begin
            s0_vld_q  <= s0_vld_d;
            s0_x_q    <= s0_x_d;
            s0_y_q    <= s0_y_d;
            s0_w_q    <= s0_w_d;
            s0_mode_q <= s0_mode_d;
            bf_vld_q  <= bf_vld_d;
            bf_x_q    <= bf_x_d;
            bf_y_q    <= bf_y_d;
            bf_mode_q <= bf_mode_d;
        end
    end

`ifdef NTT_HALF_SCALE_EN
    // Multiplying by 2^-1 mod Q: an odd value becomes even by adding the odd Q.
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] s;
        s = v[0] ? ({1'b0, v} + QW) : {1'b0, v};
        return WIDTH'(s >> 1);
    endfunction

    logic             hs_vld_d, hs_vld_q;
    logic [WIDTH-1:0] hs_x_d, hs_x_q, hs_y_d, hs_y_q;

    always_comb begin
        hs_vld_d = bf_vld_q;
        hs_x_d   = hs_x_q;
        hs_y_d   = hs_y_q;
        if (bf_vld_q) begin
            hs_x_d = (bf_mode_q == MODE_GS) ? half_mod(bf_x_q) : bf_x_q;
            hs_y_d = (bf_mode_q == MODE_GS) ? half_mod(bf_y_q) : bf_y_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_vld_q <= 1'b0;
            hs_x_q   <= '0;
            hs_y_q   <= '0;
        end else begin
            hs_vld_q <= hs_vld_d;
            hs_x_q   <= hs_x_d;
            hs_y_q   <= hs_y_d;
        end
    end

    assign xout  = hs_x_q;
    assign yout  = hs_y_q;
    assign valid = hs_vld_q;
`else
    // Without scaling only the GS mode bit rides into the output stage unused.
    logic unused_mode;
    assign unused_mode = bf_mode_q;

    assign xout  = bf_x_q;
    assign yout  = bf_y_q;
    assign valid = bf_vld_q;
`endif

endmodule

// File: tb/tb_ntt_bfly_pipe.sv
// Directed bench for ntt_bfly_pipe (Q=12289, MUL_STAGES=2); honours NTT_HALF_SCALE_EN.
module tb_ntt_bfly_pipe;

    localparam int W = 16;
`ifdef NTT_HALF_SCALE_EN
    localparam int LAT = 5;
    localparam bit HS  = 1'b1;
`else
    localparam int LAT = 4;
    localparam bit HS  = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] xin = '0, yin = '0, wr = '0;
    logic         mode = 1'b0, en = 1'b0;
    logic [W-1:0] xout, yout;
    logic         valid;

    ntt_bfly_pipe #(
        .WIDTH      (W),
        .MODULUS    (12289),
        .MUL_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .xin   (xin),
        .yin   (yin),
        .wr    (wr),
        .mode  (mode),
        .en    (en),
        .xout  (xout),
        .yout  (yout),
        .valid (valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed vectors; columns hx/hy are the results with GS half scaling.
    logic [W-1:0] tv_x  [8] = '{1,     10,    12288, 12288, 100,   5,     5,     12288};
    logic [W-1:0] tv_y  [8] = '{2,     3,     12288, 12288, 200,   9,     12288, 1};
    logic [W-1:0] tv_w  [8] = '{3,     5,     12288, 12288, 2,     7,     2,     3};
    logic         tv_m  [8] = '{0,     1,     0,     1,     0,     1,     0,     1};
    logic [W-1:0] tv_ex [8] = '{7,     13,    0,     12287, 500,   14,    3,     0};
    logic [W-1:0] tv_ey [8] = '{12284, 35,    12287, 0,     11989, 12261, 7,     12283};
    logic [W-1:0] tv_hx [8] = '{7,     6151,  0,     12288, 500,   7,     3,     0};
    logic [W-1:0] tv_hy [8] = '{12284, 6162,  12287, 0,     11989, 12275, 7,     12286};

    logic [W-1:0] exp_x_q[$];
    logic [W-1:0] exp_y_q[$];
    int           exp_t_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [W-1:0] exp_x(input int i);
        return HS ? tv_hx[i] : tv_ex[i];
    endfunction

    function automatic logic [W-1:0] exp_y(input int i);
        return HS ? tv_hy[i] : tv_ey[i];
    endfunction

    task automatic send(input int i);
        @(negedge clk);
        xin  = tv_x[i];
        yin  = tv_y[i];
        wr   = tv_w[i];
        mode = tv_m[i];
        en   = 1'b1;
        exp_x_q.push_back(exp_x(i));
        exp_y_q.push_back(exp_y(i));
        exp_t_q.push_back(cyc + LAT);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    task automatic flush_expected();
        exp_x_q.delete();
        exp_y_q.delete();
        exp_t_q.delete();
    endtask

    // Scoreboard: every valid must match the oldest expectation at its due cycle.
    logic         mon_en = 1'b0;
    int           mon_t;
    logic [W-1:0] mon_x, mon_y;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (valid) begin
                if (exp_t_q.size() == 0) begin
                    check("spurious_valid", valid, 0);
                end else begin
                    mon_t = exp_t_q.pop_front();
                    mon_x = exp_x_q.pop_front();
                    mon_y = exp_y_q.pop_front();
                    check("valid_cycle", cyc, mon_t);
                    check("xout", xout, mon_x);
                    check("yout", yout, mon_y);
                end
            end else if (exp_t_q.size() != 0 && exp_t_q[0] <= cyc) begin
                check("missing_valid", valid, 1);
                mon_t = exp_t_q.pop_front();
                mon_x = exp_x_q.pop_front();
                mon_y = exp_y_q.pop_front();
            end
        end
    end

    logic stale;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_xout", xout, 0);
        check("rst_yout", yout, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Isolated CT, GS and wrap-around samples, then output hold.
        for (int i = 0; i < 4; i++) begin
            send(i);
            idle(LAT + 2);
            check("hold_valid", valid, 0);
            check("hold_xout", xout, exp_x(i));
            check("hold_yout", yout, exp_y(i));
        end

        // Back-to-back stream with alternating modes.
        for (int i = 0; i < 8; i++) send(i);
        idle(LAT + 2);
        check("stream_drained", exp_t_q.size(), 0);

        // Reset in the middle of a six-sample burst while results are emerging.
        for (int i = 0; i < 6; i++) send(i);
        @(negedge clk);
        en = 1'b0;
        #2;
        check("pre_rst_valid", valid, 1);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_xout", xout, 0);
        check("async_rst_yout", yout, 0);
        flush_expected();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        stale = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            stale = stale | valid;
        end
        check("no_stale_valid", stale, 0);
        check("post_rst_xout", xout, 0);

        mon_en = 1'b1;
        send(5);
        send(6);
        idle(LAT + 2);
        check("final_drained", exp_t_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
